// File: rtl/pwm_dt_pkg.sv
// Shared definitions for the dead-time generator: FSM state encoding and default widths.
package pwm_dt_pkg;

  localparam int DT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LO_ON   = 3'd1,
    ST_DT_RISE = 3'd2,
    ST_HI_ON   = 3'd3,
    ST_DT_FALL = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  function automatic logic is_band(input state_e s);
    return (s == ST_DT_RISE) || (s == ST_DT_FALL);
  endfunction

endpackage

// File: rtl/pwm_deadtime_gen_sync_2ff.sv
// Two-flop synchroniser for an asynchronous active-low input; resets to the inactive level 1.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Half-bridge gate driver: complementary gates with a programmable dead band on every edge.
// Optional latched fault input enabled by defining DEADTIME_FAULT_EN.
module pwm_deadtime_gen
  import pwm_dt_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dt_cycles,
`ifdef DEADTIME_FAULT_EN
  input  logic            fault_n,
  input  logic            fault_clr,
  output logic            fault_latched,
`endif
  output logic            gate_hi,
  output logic            gate_lo,
  output logic            in_deadband,
  output logic            swallow,
  output logic [2:0]      dbg_state
);

  state_e          r_state;
  state_e          w_next;
  logic [DT_W-1:0] r_cnt;
  logic [DT_W-1:0] w_cnt_next;
  logic [DT_W-1:0] w_d;
  logic            w_swallow;
  logic            r_gate_hi;
  logic            r_gate_lo;
  logic            r_in_deadband;
  logic            r_swallow;

`ifdef DEADTIME_FAULT_EN
  logic w_fault_n_sync;
  logic r_fault_latched;

  sync_2ff u_fault_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (fault_n),
    .o_q   (w_fault_n_sync)
  );
`endif

  assign w_d = (dt_cycles == '0) ? DT_W'(1) : dt_cycles;

  // A pwm_in reversal inside a band is checked before expiry so an aborted band never drives.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_swallow  = 1'b0;
`ifdef DEADTIME_FAULT_EN
    if (!w_fault_n_sync) begin
      w_next     = ST_FAULT;
      w_cnt_next = '0;
    end else if (r_state == ST_FAULT) begin
      w_cnt_next = '0;
      if (fault_clr) w_next = ST_IDLE;
    end else
`endif
    if (!en) begin
      w_next     = ST_IDLE;
      w_cnt_next = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_next     = pwm_in ? ST_DT_RISE : ST_DT_FALL;
          w_cnt_next = w_d - DT_W'(1);
        end
        ST_LO_ON: begin
          if (pwm_in) begin
            w_next     = ST_DT_RISE;
            w_cnt_next = w_d - DT_W'(1);
          end
        end
        ST_HI_ON: begin
          if (!pwm_in) begin
            w_next     = ST_DT_FALL;
            w_cnt_next = w_d - DT_W'(1);
          end
        end
        ST_DT_RISE: begin
          if (!pwm_in) begin
            w_next     = ST_LO_ON;
            w_cnt_next = '0;
            w_swallow  = 1'b1;
          end else if (r_cnt == '0) begin
            w_next = ST_HI_ON;
          end else begin
            w_cnt_next = r_cnt - DT_W'(1);
          end
        end
        ST_DT_FALL: begin
          if (pwm_in) begin
            w_next     = ST_HI_ON;
            w_cnt_next = '0;
            w_swallow  = 1'b1;
          end else if (r_cnt == '0) begin
            w_next = ST_LO_ON;
          end else begin
            w_cnt_next = r_cnt - DT_W'(1);
          end
        end
        default: begin
          w_next     = ST_IDLE;
          w_cnt_next = '0;
        end
      endcase
    end
  end

  // Outputs are a Moore decode of the next state so gates move on the sampling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_gate_hi     <= 1'b0;
      r_gate_lo     <= 1'b0;
      r_in_deadband <= 1'b0;
      r_swallow     <= 1'b0;
`ifdef DEADTIME_FAULT_EN
      r_fault_latched <= 1'b0;
`endif
    end else begin
      r_state       <= w_next;
      r_cnt         <= w_cnt_next;
      r_gate_hi     <= (w_next == ST_HI_ON);
      r_gate_lo     <= (w_next == ST_LO_ON);
      r_in_deadband <= is_band(w_next);
      r_swallow     <= w_swallow;
`ifdef DEADTIME_FAULT_EN
      r_fault_latched <= (w_next == ST_FAULT);
`endif
    end
  end

  assign gate_hi     = r_gate_hi;
  assign gate_lo     = r_gate_lo;
  assign in_deadband = r_in_deadband;
  assign swallow     = r_swallow;
  assign dbg_state   = r_state;
`ifdef DEADTIME_FAULT_EN
  assign fault_latched = r_fault_latched;
`endif

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Self-checking bench for pwm_deadtime_gen: directed edge/abort/enable/reset cases plus a random soak
// against a timestamp-based reference model. Fault cases run when DEADTIME_FAULT_EN is defined.
module tb_pwm_deadtime_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] dt_cycles = 8'd0;
  logic       gate_hi;
  logic       gate_lo;
  logic       in_deadband;
  logic       swallow;
  logic [2:0] dbg_state;
`ifdef DEADTIME_FAULT_EN
  logic       fault_n = 1'b1;
  logic       fault_clr = 1'b0;
  logic       fault_latched;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pwm_deadtime_gen #(.DT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pwm_in      (pwm_in),
    .dt_cycles   (dt_cycles),
`ifdef DEADTIME_FAULT_EN
    .fault_n     (fault_n),
    .fault_clr   (fault_clr),
    .fault_latched (fault_latched),
`endif
    .gate_hi     (gate_hi),
    .gate_lo     (gate_lo),
    .in_deadband (in_deadband),
    .swallow     (swallow),
    .dbg_state   (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: which gate is driven (0 none, 1 lo, 2 hi) and, while a band is open,
  // the edge index it opened on, its length and the side it is heading for.
  int m_drv, m_t, m_t0, m_d;
  bit m_band, m_tgt, m_sw;

  function automatic void model_reset();
    m_drv = 0; m_band = 0; m_tgt = 0; m_sw = 0; m_t = 0; m_t0 = 0; m_d = 1;
  endfunction

  function automatic void model_edge(input bit e, input bit p, input int dt);
    m_t++;
    m_sw = 0;
    if (!e) begin
      m_drv = 0;
      m_band = 0;
    end else if (m_band) begin
      if (p != m_tgt) begin
        m_band = 0; m_drv = p ? 2 : 1; m_sw = 1;
      end else if (m_t - m_t0 == m_d) begin
        m_band = 0; m_drv = m_tgt ? 2 : 1;
      end
    end else if (m_drv == 0 || ((m_drv == 2) != p)) begin
      m_band = 1; m_tgt = p; m_t0 = m_t; m_d = (dt == 0) ? 1 : dt; m_drv = 0;
    end
  endfunction

  task automatic step(input bit e, input bit p, input int dt);
    en = e; pwm_in = p; dt_cycles = dt[7:0];
    @(posedge clk);
    model_edge(e, p, dt);
    #1;
    check("gate_hi", gate_hi, (m_drv == 2));
    check("gate_lo", gate_lo, (m_drv == 1));
    check("in_deadband", in_deadband, m_band);
    check("swallow", swallow, m_sw);
  endtask

  // Hold pwm_in at p until the matching gate turns on; n counts edges including the sampling edge.
  task automatic lat_to(input bit p, input int dt, output int n);
    n = 0;
    do begin
      step(1'b1, p, dt);
      n++;
    end while (((p ? gate_hi : gate_lo) == 1'b0) && n < 300);
  endtask

  always @(negedge clk) begin
    if (rst_n) check("overlap", (gate_hi & gate_lo), 0);
  end

  initial begin
    #5_000_000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    int sw_cnt;
    bit hi_seen;
    bit p;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_gate_hi", gate_hi, 0);
    check("rst_gate_lo", gate_lo, 0);
    check("rst_deadband", in_deadband, 0);
    check("rst_swallow", swallow, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    lat_to(1'b0, 4, n);
    check("release_lat_dt4", n, 5);

    lat_to(1'b1, 3, n);
    check("rise_lat_dt3", n, 4);
    lat_to(1'b0, 3, n);
    check("fall_lat_dt3", n, 4);

    hi_seen = 0; sw_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i < 4), 10);
      if (gate_hi) hi_seen = 1;
      if (swallow) sw_cnt++;
    end
    check("swallow_hi_seen", hi_seen, 0);
    check("swallow_pulses", sw_cnt, 1);
    check("swallow_lo_back", gate_lo, 1);

    lat_to(1'b1, 0, n);
    check("rise_lat_dt0", n, 2);
    lat_to(1'b0, 0, n);
    check("fall_lat_dt0", n, 2);

    step(1'b1, 1'b1, 2);
    n = 1;
    do begin
      step(1'b1, 1'b1, 8);
      n++;
    end while (!gate_hi && n < 300);
    check("dt_midband_lat", n, 3);
    lat_to(1'b0, 8, n);
    check("dt_next_band_lat", n, 9);

    lat_to(1'b1, 4, n);
    check("hi_before_en", gate_hi, 1);
    step(1'b0, 1'b1, 4);
    check("en_off_hi", gate_hi, 0);
    check("en_off_lo", gate_lo, 0);
    lat_to(1'b1, 5, n);
    check("en_on_lat", n, 6);

    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_hi", gate_hi, 0);
    check("async_rst_lo", gate_lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    lat_to(1'b1, 2, n);
    check("post_rst_lat", n, 3);

`ifdef DEADTIME_FAULT_EN
    @(negedge clk);
    fault_n = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while ((gate_hi || gate_lo || !fault_latched) && n < 20);
    check("fault_entry_edges", (n <= 3), 1);
    fault_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("fault_clr_held_low", fault_latched, 1);
    fault_clr = 1'b0;
    fault_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("fault_no_clr", fault_latched, 1);
    check("fault_gates", (gate_hi | gate_lo), 0);
    fault_clr = 1'b1;
    @(posedge clk);
    #1;
    check("fault_exit", fault_latched, 0);
    check("fault_exit_state", dbg_state, 0);
    fault_clr = 1'b0;
    model_reset();
    lat_to(1'b0, 3, n);
    check("fault_recover_lat", n, 4);
`endif

    p = pwm_in;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 99) < 9) p = ~p;
      step(($urandom_range(0, 399) != 0), p, $urandom_range(0, 12));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
